axi4_write_response_slave: RTL and testbench
============================================

// Module: axi4_write_response_slave
// PURPOSE
//  Subordinate-side AXI4-Lite write response (B) channel transmitter.
//  - Slave write datapath reports each completed write as a one-cycle resp_push with a response code.
//  - Block queues these responses and drives BVALID/BRESP to the manager under AXI handshake rules.
//  - It is the counterpart of the manager-side B-channel receiver and sits beside the slave AW/W logic.
// PARAMETERS
//  DEPTH   2   queue entries behind the output register; power of 2, >=1; total capacity DEPTH+1
//  CNT_W   $clog2(DEPTH+2)   width of pend_count (derived localparam, not overridable)
// PORTS
//  ACLK           in   1      clock
//  ARESETN        in   1      reset, asynchronous, active-low
//  resp_push      in   1      write-completion strobe from slave write logic, one response per cycle high
//  resp_code      in   2      BRESP value for the pushed response (00 OKAY, 01 EXOKAY, 10 SLVERR, 11 DECERR)
//  resp_full      out  1      queue full; combinational, = (queue count == DEPTH)
//  BVALID         out  1      write response valid to manager
//  BRESP          out  2      write response to manager
//  BREADY         in   1      manager ready
//  b_idle         out  1      1 when BVALID=0 and queue empty
//  b_done         out  1      one-cycle pulse the cycle after each B handshake
//  pend_count     out  CNT_W  responses held: queue count + BVALID
//  resp_overflow  out  1      sticky; set when a push is dropped, cleared only by reset
// BEHAVIOUR
//  Reset values (asynchronous): BVALID=0, BRESP=00, b_done=0, resp_overflow=0, queue empty, pend_count=0.
//    b_idle=1, resp_full=0.
//  Handshake: hs = BVALID & BREADY at a rising ACLK edge.
//  FSM states:
//    S_IDLE (BVALID=0), S_SEND (BVALID=1).
//    S_IDLE->S_SEND on an accepted push.
//    S_SEND->S_IDLE on hs with the queue empty and no accepted push.
//    Otherwise S_SEND holds.
//  Latency: push in S_IDLE -> BVALID=1 with BRESP=resp_code on the next cycle.
//    No combinational path from resp_push to BVALID.
//  While BVALID=1 and BREADY=0, BVALID and BRESP stay stable.
//    No retraction and no code change, whatever the push/queue activity.
//  BVALID does not wait for BREADY. A BREADY high before BVALID causes no transfer.
//  A push is accepted iff resp_push=1 and resp_full=0.
//    Otherwise it is dropped and resp_overflow<=1.
//    This holds even if hs occurs the same cycle.
//  Accepted-push routing, evaluated at one edge:
//    S_IDLE -> output register.
//    S_SEND, no hs -> queue tail.
//    S_SEND, hs, queue empty -> output register directly (bypass); BVALID stays 1 back-to-back.
//    S_SEND, hs, queue non-empty -> head to output register, push to tail; count unchanged.
//  hs without push:
//    Queue non-empty -> head loads the output register; BVALID stays 1, zero-bubble back-to-back.
//    Queue empty -> BVALID<=0.
//  Ordering: responses are issued strictly in push order.
//  b_done: registered, = hs of the previous cycle; back-to-back hs gives b_done high on consecutive cycles.
//  pend_count: updated every edge as +accepted push -hs, range 0..DEPTH+1.
//    resp_full can be 1 while pend_count = DEPTH+1.
//  Pointers: wrap modulo DEPTH; the queue keeps a separate count register so full vs empty is unambiguous.
//  Reset mid-transfer: BVALID drops asynchronously and queued responses are discarded.
//    The slave write logic must reset with the same ARESETN.
//  resp_code is passed through unchanged; no legality checks.
// STRUCTURE
//  Shared package axi4_lite_pkg holds:
//    RESP_OKAY=2'b00, RESP_EXOKAY=2'b01, RESP_SLVERR=2'b10, RESP_DECERR=2'b11.
//    The B-channel state encodings S_IDLE/S_SEND.
//  One sub-module: axi4_resp_fifo.
//    Synchronous FIFO, WIDTH=2, DEPTH; push/pop/full/empty/count; first-word data on rd_data, not registered.
//  Top level holds the FSM, output register, bypass mux, b_done and overflow flags.
// TESTING
//  1 Single: push resp_code=00 while BREADY=1 -> BVALID=1,BRESP=00 next cycle; hs; b_done=1 one cycle later; b_idle=1.
//  2 Backpressure: push 10, BREADY=0 for 5 cycles -> BVALID/BRESP=10 held stable all 5; BREADY=1 -> one hs, BVALID=0.
//  3 Burst DEPTH=2, BREADY=0: push 00,10,11 -> resp_full=1, pend_count=3; 4th push dropped, resp_overflow=1.
//    Then BREADY=1 -> BRESP 00,10,11 on 3 consecutive cycles, BVALID continuous.
//  4 Bypass: BVALID=1, queue empty, BREADY=1, push 01 same cycle -> BVALID stays 1, BRESP=01 next cycle, pend_count=1.
//  5 Full+hs: queue full, hs and push in the same cycle -> push dropped, overflow set, pend_count decrements by 1.
//  6 Reset: ARESETN low with BVALID=1 and 2 queued -> BVALID=0 immediately, pend_count=0;
//    after release the first push is issued normally.

Source files
------------

// File: rtl/axi4_lite_pkg.sv
// Shared AXI4-Lite definitions: BRESP codes and B-channel FSM state encodings.
// Latency: n/a (constants and types only).
// Backpressure: n/a.
package axi4_lite_pkg;

   typedef logic [1:0] resp_t;

   localparam resp_t RESP_OKAY   = 2'b00;
   localparam resp_t RESP_EXOKAY = 2'b01;
   localparam resp_t RESP_SLVERR = 2'b10;
   localparam resp_t RESP_DECERR = 2'b11;

   // B-channel transmitter states; S_SEND is exactly BVALID=1
   localparam logic [0:0] S_IDLE = 1'b0;
   localparam logic [0:0] S_SEND = 1'b1;

endpackage

// File: rtl/axi4_resp_fifo.sv
// Small synchronous FIFO holding responses queued behind the B output register.
// Latency: write visible on rd_data the cycle after push; rd_data is the head, unregistered.
// Backpressure: push ignored when full, pop ignored when empty; caller gates with full/empty.
module axi4_resp_fifo #(
   parameter int WIDTH = 2,
   parameter int DEPTH = 2,
   localparam int CW   = $clog2(DEPTH + 1),
   localparam int PW   = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             push,
   input  logic [WIDTH-1:0] wr_data,
   input  logic             pop,
   output logic [WIDTH-1:0] rd_data,
   output logic             full,
   output logic             empty,
   output logic [CW-1:0]    count
);

   logic [WIDTH-1:0] mem_q [DEPTH];
   logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
   logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
   logic [CW-1:0]    count_q, count_d;
   logic             do_push;
   logic             do_pop;

   assign full    = (count_q == CW'(DEPTH));
   assign empty   = (count_q == '0);
   assign count   = count_q;
   assign rd_data = mem_q[rd_ptr_q];

   assign do_push = push & ~full;
   assign do_pop  = pop & ~empty;

   // Next-state pointers wrap at DEPTH; a separate count disambiguates full from empty
   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (do_push) begin
         wr_ptr_d = (wr_ptr_q == PW'(DEPTH - 1)) ? '0 : wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
         rd_ptr_d = (rd_ptr_q == PW'(DEPTH - 1)) ? '0 : rd_ptr_q + 1'b1;
      end
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + 1'b1;
         2'b01:   count_d = count_q - 1'b1;
         default: count_d = count_q;
      endcase
   end

   // Pointer and count registers; contents are discarded by reset
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   // Storage write; no reset needed since count gates every read
   always_ff @(posedge ACLK) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= wr_data;
      end
   end

endmodule

// File: rtl/axi4_write_response_slave.sv
// AXI4-Lite subordinate B-channel transmitter: queues write completions and issues them in order.
// Latency: push while idle -> BVALID next cycle; zero-bubble back-to-back responses on handshake.
// Backpressure: BVALID/BRESP held stable while BREADY=0; pushes dropped (sticky overflow) when queue full.
module axi4_write_response_slave
   import axi4_lite_pkg::*;
#(
   parameter int DEPTH = 2,
   localparam int CNT_W = $clog2(DEPTH + 2)
) (
   input  logic             ACLK,
   input  logic             ARESETN,
   input  logic             resp_push,
   input  logic [1:0]       resp_code,
   output logic             resp_full,
   output logic             BVALID,
   output logic [1:0]       BRESP,
   input  logic             BREADY,
   output logic             b_idle,
   output logic             b_done,
   output logic [CNT_W-1:0] pend_count,
   output logic             resp_overflow
);

   localparam int QCW = $clog2(DEPTH + 1);

   logic [0:0]   state_q, state_d;
   logic [1:0]   bresp_q, bresp_d;
   logic         b_done_q;
   logic         overflow_q;
   logic         hs;
   logic         push_acc;
   logic         fifo_push;
   logic         fifo_pop;
   logic         fifo_full;
   logic         fifo_empty;
   logic [1:0]   fifo_rd_data;
   logic [QCW-1:0] fifo_count;

   assign BVALID        = (state_q == S_SEND);
   assign BRESP         = bresp_q;
   assign hs            = BVALID & BREADY;
   assign resp_full     = fifo_full;
   assign push_acc      = resp_push & ~fifo_full;
   assign b_idle        = ~BVALID & fifo_empty;
   assign b_done        = b_done_q;
   assign resp_overflow = overflow_q;
   assign pend_count    = CNT_W'(fifo_count) + CNT_W'(BVALID);

   // A push goes to the queue only when the output register is occupied and not being bypassed
   assign fifo_push = push_acc & BVALID & ~(hs & fifo_empty);
   assign fifo_pop  = hs & ~fifo_empty;

   axi4_resp_fifo #(
      .WIDTH (2),
      .DEPTH (DEPTH)
   ) u_fifo (
      .ACLK    (ACLK),
      .ARESETN (ARESETN),
      .push    (fifo_push),
      .wr_data (resp_code),
      .pop     (fifo_pop),
      .rd_data (fifo_rd_data),
      .full    (fifo_full),
      .empty   (fifo_empty),
      .count   (fifo_count)
   );

   // Output register loads from push when idle, then from queue head or bypass on each handshake
   always_comb begin
      state_d = state_q;
      bresp_d = bresp_q;
      case (state_q)
         S_IDLE: begin
            if (push_acc) begin
               state_d = S_SEND;
               bresp_d = resp_code;
            end
         end
         default: begin
            if (hs) begin
               if (!fifo_empty) begin
                  bresp_d = fifo_rd_data;
               end else if (push_acc) begin
                  bresp_d = resp_code;
               end else begin
                  state_d = S_IDLE;
               end
            end
         end
      endcase
   end

   // FSM, output register, completion pulse and sticky overflow flag
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         state_q    <= S_IDLE;
         bresp_q    <= RESP_OKAY;
         b_done_q   <= 1'b0;
         overflow_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         bresp_q  <= bresp_d;
         b_done_q <= hs;
         if (resp_push && fifo_full) begin
            overflow_q <= 1'b1;
         end
      end
   end

endmodule

// File: tb/tb_axi4_write_response_slave.sv
// Directed bench for the AXI4-Lite B-channel transmitter with hand-computed expectations.
// Latency: inputs driven and outputs sampled 1ns after each rising edge.
// Backpressure: BREADY driven directly by the scenarios.
module tb_axi4_write_response_slave;

   logic       ACLK;
   logic       ARESETN;
   logic       resp_push;
   logic [1:0] resp_code;
   logic       resp_full;
   logic       BVALID;
   logic [1:0] BRESP;
   logic       BREADY;
   logic       b_idle;
   logic       b_done;
   logic [1:0] pend_count;
   logic       resp_overflow;

   int checks;
   int failures;

   axi4_write_response_slave #(.DEPTH(2)) dut (
      .ACLK          (ACLK),
      .ARESETN       (ARESETN),
      .resp_push     (resp_push),
      .resp_code     (resp_code),
      .resp_full     (resp_full),
      .BVALID        (BVALID),
      .BRESP         (BRESP),
      .BREADY        (BREADY),
      .b_idle        (b_idle),
      .b_done        (b_done),
      .pend_count    (pend_count),
      .resp_overflow (resp_overflow)
   );

   initial ACLK = 1'b0;
   always #5 ACLK = ~ACLK;

   task automatic tick();
      @(posedge ACLK);
      #1;
   endtask

   task automatic push(input logic [1:0] code);
      resp_push = 1'b1;
      resp_code = code;
      tick();
      resp_push = 1'b0;
   endtask

   task automatic test_reset();
      checks++;
      if ({BVALID, BRESP, b_done, resp_overflow, pend_count, b_idle, resp_full} !== 9'b0_00_0_0_00_1_0) begin
         failures++;
         $display("FAIL reset_state got=%b want=%b",
                  {BVALID, BRESP, b_done, resp_overflow, pend_count, b_idle, resp_full}, 9'b0_00_0_0_00_1_0);
      end
   endtask

   task automatic test_single();
      BREADY = 1'b1;
      push(2'b00);
      checks++;
      if ({BVALID, BRESP, pend_count} !== 5'b1_00_01) begin
         failures++;
         $display("FAIL single_issue got=%b want=%b", {BVALID, BRESP, pend_count}, 5'b1_00_01);
      end
      tick();
      checks++;
      if ({BVALID, b_done, b_idle, pend_count} !== 5'b0_1_1_00) begin
         failures++;
         $display("FAIL single_done got=%b want=%b", {BVALID, b_done, b_idle, pend_count}, 5'b0_1_1_00);
      end
      tick();
      checks++;
      if (b_done !== 1'b0) begin
         failures++;
         $display("FAIL single_done_pulse got=%b want=0", b_done);
      end
   endtask

   task automatic test_backpressure();
      BREADY = 1'b0;
      push(2'b10);
      for (int i = 0; i < 5; i++) begin
         checks++;
         if ({BVALID, BRESP, b_done} !== 4'b1_10_0) begin
            failures++;
            $display("FAIL bp_hold cyc=%0d got=%b want=%b", i, {BVALID, BRESP, b_done}, 4'b1_10_0);
         end
         tick();
      end
      BREADY = 1'b1;
      tick();
      BREADY = 1'b0;
      checks++;
      if ({BVALID, b_done, pend_count} !== 4'b0_1_00) begin
         failures++;
         $display("FAIL bp_release got=%b want=%b", {BVALID, b_done, pend_count}, 4'b0_1_00);
      end
      tick();
      checks++;
      if ({BVALID, b_done} !== 2'b00) begin
         failures++;
         $display("FAIL bp_single_hs got=%b want=00", {BVALID, b_done});
      end
   endtask

   task automatic test_bypass();
      BREADY = 1'b0;
      push(2'b10);
      BREADY = 1'b1;
      push(2'b01);
      checks++;
      if ({BVALID, BRESP, pend_count, b_done} !== 6'b1_01_01_1) begin
         failures++;
         $display("FAIL bypass got=%b want=%b", {BVALID, BRESP, pend_count, b_done}, 6'b1_01_01_1);
      end
      tick();
      BREADY = 1'b0;
      checks++;
      if ({BVALID, pend_count, b_idle} !== 4'b0_00_1) begin
         failures++;
         $display("FAIL bypass_drain got=%b want=%b", {BVALID, pend_count, b_idle}, 4'b0_00_1);
      end
   endtask

   task automatic test_burst();
      logic [1:0] exp_seq [3];
      exp_seq[0] = 2'b00;
      exp_seq[1] = 2'b10;
      exp_seq[2] = 2'b11;
      BREADY = 1'b0;
      push(2'b00);
      push(2'b10);
      push(2'b11);
      checks++;
      if ({resp_full, pend_count, BVALID, BRESP, resp_overflow} !== 7'b1_11_1_00_0) begin
         failures++;
         $display("FAIL burst_full got=%b want=%b",
                  {resp_full, pend_count, BVALID, BRESP, resp_overflow}, 7'b1_11_1_00_0);
      end
      push(2'b01);
      checks++;
      if ({resp_overflow, pend_count, BRESP} !== 5'b1_11_00) begin
         failures++;
         $display("FAIL burst_overflow got=%b want=%b", {resp_overflow, pend_count, BRESP}, 5'b1_11_00);
      end
      BREADY = 1'b1;
      for (int i = 0; i < 3; i++) begin
         checks++;
         if ({BVALID, BRESP} !== {1'b1, exp_seq[i]}) begin
            failures++;
            $display("FAIL burst_order idx=%0d got=%b want=%b", i, {BVALID, BRESP}, {1'b1, exp_seq[i]});
         end
         tick();
      end
      BREADY = 1'b0;
      checks++;
      if ({BVALID, pend_count, resp_overflow} !== 4'b0_00_1) begin
         failures++;
         $display("FAIL burst_end got=%b want=%b", {BVALID, pend_count, resp_overflow}, 4'b0_00_1);
      end
   endtask

   task automatic test_reset_mid();
      BREADY = 1'b0;
      push(2'b00);
      push(2'b01);
      push(2'b10);
      ARESETN = 1'b0;
      #1;
      checks++;
      if ({BVALID, pend_count, resp_overflow, b_idle, resp_full} !== 6'b0_00_0_1_0) begin
         failures++;
         $display("FAIL reset_mid got=%b want=%b",
                  {BVALID, pend_count, resp_overflow, b_idle, resp_full}, 6'b0_00_0_1_0);
      end
      #3;
      ARESETN = 1'b1;
      BREADY  = 1'b1;
      push(2'b11);
      checks++;
      if ({BVALID, BRESP, pend_count} !== 5'b1_11_01) begin
         failures++;
         $display("FAIL reset_after_push got=%b want=%b", {BVALID, BRESP, pend_count}, 5'b1_11_01);
      end
      tick();
      BREADY = 1'b0;
      checks++;
      if ({BVALID, pend_count, b_done} !== 4'b0_00_1) begin
         failures++;
         $display("FAIL reset_after_drain got=%b want=%b", {BVALID, pend_count, b_done}, 4'b0_00_1);
      end
   endtask

   task automatic test_full_hs();
      BREADY = 1'b0;
      push(2'b00);
      push(2'b01);
      push(2'b10);
      BREADY = 1'b1;
      push(2'b11);
      checks++;
      if ({pend_count, resp_overflow, BVALID, BRESP, resp_full} !== 7'b10_1_1_01_0) begin
         failures++;
         $display("FAIL full_hs got=%b want=%b",
                  {pend_count, resp_overflow, BVALID, BRESP, resp_full}, 7'b10_1_1_01_0);
      end
      tick();
      checks++;
      if ({BVALID, BRESP, pend_count} !== 5'b1_10_01) begin
         failures++;
         $display("FAIL full_hs_next got=%b want=%b", {BVALID, BRESP, pend_count}, 5'b1_10_01);
      end
      tick();
      BREADY = 1'b0;
      checks++;
      if ({BVALID, pend_count, b_idle} !== 4'b0_00_1) begin
         failures++;
         $display("FAIL full_hs_drop got=%b want=%b", {BVALID, pend_count, b_idle}, 4'b0_00_1);
      end
   endtask

   initial begin
      checks    = 0;
      failures  = 0;
      ARESETN   = 1'b0;
      resp_push = 1'b0;
      resp_code = 2'b00;
      BREADY    = 1'b0;
      #2;
      test_reset();
      #10;
      ARESETN = 1'b1;
      tick();
      test_reset();
      test_single();
      test_backpressure();
      test_bypass();
      test_burst();
      test_reset_mid();
      test_full_hs();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
